// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// a counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(log2(n)), never below 1 so a WIDTH=1 counter still has a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full-adder cell; the serial subtractor feeds it inverted subtrahend
// bits and reuses it every SHIFT cycle.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/n_bit_twos_complement_serial_sub.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock; result after WIDTH clocks.
// Optional SERIAL_SUB_ADD_MODE_EN adds an op_sub port selecting add (0) or subtract (1).
module n_bit_twos_complement_serial_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = clog2_min1(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             last_bit;
  logic             cell_s;
  logic             cell_cout;
  logic             sub_sel;   // operation requested at the accept edge
  logic             sub_mode;  // operation of the transaction in flight

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic sub_mode_q, sub_mode_d;

  assign sub_sel  = op_sub;
  assign sub_mode = sub_mode_q;

  always_comb begin
    sub_mode_d = sub_mode_q;
    if (accept) sub_mode_d = op_sub;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_mode_q <= 1'b1;
    else        sub_mode_q <= sub_mode_d;
  end
`else
  assign sub_sel  = 1'b1;
  assign sub_mode = 1'b1;
`endif

  assign accept   = in_valid && (state_q == IDLE);
  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  sub_bit_cell u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath: load on accept, shift one bit per SHIFT cycle
  always_comb begin
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    diff_d       = diff_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = sub_sel ? ~b : b;
      carry_d = sub_sel ? ~borrow_in : borrow_in;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_sr_d            = a_sr_q >> 1;
      b_sr_d            = b_sr_q >> 1;
      diff_d            = diff_q >> 1;
      diff_d[WIDTH-1]   = cell_s;
      carry_d           = cell_cout;
      cnt_d             = cnt_q + CW'(1);
      if (last_bit) begin
        // carry_q here is the carry into the MSB position
        overflow_d   = carry_q ^ cell_cout;
        borrow_out_d = sub_mode ? ~cell_cout : cell_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      diff_q       <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      diff_q       <= diff_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_n_bit_twos_complement_serial_sub.sv
// Directed bench for the bit-serial subtractor at WIDTH=6 with hand-computed results.
module tb_n_bit_twos_complement_serial_sub;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_tests;
  int n_fail;

  n_bit_twos_complement_serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op_sub     (1'b1),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operation, time it, check results, optionally stall out_ready.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                        input logic exp_ov, input int hold, input bit noise);
    int lat;
    logic [W-1:0] d0;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (noise) begin
      in_valid  = 1'b1;
      a         = 6'h2a;
      b         = 6'h15;
      borrow_in = 1'b1;
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) chk({tag, "_in_ready_shift"}, in_ready, 0);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_borrow"}, borrow_out, exp_bo);
    chk({tag, "_ovf"}, overflow, exp_ov);
    d0 = diff;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      chk({tag, "_hold_diff"}, diff, d0);
      chk({tag, "_hold_borrow"}, borrow_out, exp_bo);
      chk({tag, "_hold_ovf"}, overflow, exp_ov);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
    chk({tag, "_diff_kept"}, diff, exp_d);
  endtask

  initial begin
    int seen;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    run_op("5m3",   6'd5,      6'd3,      1'b0, 6'b000010, 1'b0, 1'b0, 0, 1'b0);
    run_op("3m5",   6'd3,      6'd5,      1'b0, 6'b111110, 1'b1, 1'b0, 0, 1'b1);
    run_op("neg32", 6'b100000, 6'b000001, 1'b0, 6'b011111, 1'b0, 1'b1, 0, 1'b0);
    run_op("31mm1", 6'b011111, 6'b111111, 1'b0, 6'b100000, 1'b1, 1'b1, 0, 1'b0);
    run_op("hold",  6'd0,      6'd0,      1'b1, 6'b111111, 1'b1, 1'b0, 10, 1'b0);

    // Abort mid-SHIFT with reset
    @(negedge clk);
    in_valid = 1'b1;
    a        = 6'd9;
    b        = 6'd4;
    borrow_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
    chk("abort_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run_op("9m4", 6'd9, 6'd4, 1'b0, 6'b000101, 1'b0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n_bit_twos_complement_serial_sub.md
Name: n_bit_twos_complement_serial_sub

Overview:
- Bit-serial two's complement subtractor: computes diff = a - b - borrow_in one bit per clock, LSB first.
- Uses a single full-adder-style cell with b inverted and carry-in = ~borrow_in.
- Counterpart to the combinational parallel ripple adder. Used where area matters more than latency, and as the subtract path for the arithmetic test harnesses.
- Operands in and results out each use a valid/ready handshake.

Parameters:
- WIDTH, 5, operand and result width in bits (>= 1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operands a, b, borrow_in are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, two's complement
- b  input  WIDTH  subtrahend, two's complement
- borrow_in  input  1  initial borrow
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b - borrow_in) mod 2^WIDTH
- borrow_out  output  1  unsigned borrow out of the MSB (= ~carry out)
- overflow  output  1  signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0
  - diff = 0, borrow_out = 0, overflow = 0
  - internal shift registers, carry and bit counter cleared
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: load a_sr <= a, b_sr <= ~b, carry <= ~borrow_in, cnt <= 0; go to SHIFT.
  - Operands are sampled only on this edge; later input changes are ignored.
- SHIFT:
  - in_ready = 0, out_valid = 0.
  - Each edge:
    - s = a_sr[0] ^ b_sr[0] ^ carry
    - shift s into the MSB of the diff register, shifting it right
    - shift a_sr and b_sr right
    - carry <= majority(a_sr[0], b_sr[0], carry)
    - cnt++
  - On the edge where cnt == WIDTH-1 (last bit):
    - overflow <= carry_in_msb ^ carry_out_msb
    - borrow_out <= ~carry_out_msb
    - go to DONE
- DONE:
  - out_valid = 1; diff, borrow_out and overflow are held stable.
  - On an edge with out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready = 0 in DONE, so there is no overlap of input and output transactions.
- Latency: out_valid rises exactly WIDTH clocks after the accept edge. Throughput is one operation per WIDTH+2 clocks at best.
- diff/borrow_out/overflow outside DONE:
  - hold their last completed values
  - the diff register is only partially updated during SHIFT and must not be sampled then
- Width rules:
  - all operand arithmetic is modulo 2^WIDTH
  - cnt width = clog2(WIDTH) with a minimum of 1
  - WIDTH = 1: single SHIFT cycle; the MSB is bit 0
- Boundary conditions:
  - out_ready held low: DONE holds indefinitely.
  - out_ready high in the same cycle out_valid first rises: completes on that edge.
  - in_valid asserted while not in IDLE: ignored, no queueing.
  - rst_n low at any time, including mid-SHIFT: immediate return to reset values; the partial result is discarded and no out_valid is produced.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN
- Defined:
  - adds input port op_sub (1 bit), sampled at the accept edge
  - op_sub = 1: subtract as above
  - op_sub = 0: add; b_sr <= b, carry <= borrow_in, borrow_out port reports the raw carry out, overflow computed as above
- Not defined: no op_sub port; the block always subtracts.

Decomposition:
- Shared package serial_arith_pkg:
  - FSM state encoding constants (IDLE = 0, SHIFT = 1, DONE = 2, 2-bit)
  - a clog2 constant function for counter width
- One sub-module, sub_bit_cell: combinational 1-bit cell with inputs x, y, cin and outputs s, cout. Instantiated once and reused every SHIFT cycle.

Test Plan (WIDTH=6):
- a=5, b=3, borrow_in=0 -> after 6 clocks diff=000010, borrow_out=0, overflow=0.
- a=3, b=5, borrow_in=0 -> diff=111110 (-2), borrow_out=1, overflow=0.
- a=100000 (-32), b=000001, borrow_in=0 -> diff=011111, borrow_out=0, overflow=1.
- a=011111 (31), b=111111 (-1), borrow_in=0 -> diff=100000, borrow_out=1, overflow=1.
- a=0, b=0, borrow_in=1, out_ready low for 10 cycles -> diff=111111, borrow_out=1, overflow=0; out_valid and outputs stable all 10 cycles; in_ready=0 throughout.
- Accept a=9, b=4, drop rst_n after 3 SHIFT clocks -> out_valid never asserts, in_ready=1 and outputs 0 immediately. Then 9-4 -> diff=000101.
